// File: rtl/prio_enc_pkg.sv
// Shared helpers for the priority-encoder datapath: one-hot to index conversion and one-hot checks.
package prio_enc_pkg;

    localparam int unsigned ONEHOT_MAX_W = 64;
    localparam int unsigned IDX_RET_W    = 32;

    // OR of the positions of all set bits; equals the bit index for a proper one-hot.
    function automatic logic [IDX_RET_W-1:0] onehot2idx(input logic [ONEHOT_MAX_W-1:0] onehot);
        logic [IDX_RET_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (onehot[i]) idx = idx | IDX_RET_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot0(input logic [ONEHOT_MAX_W-1:0] v);
        return (v & (v - ONEHOT_MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO: DEPTH x W storage, wrapping pointers, separate level counter.
module sync_fifo_fwft #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/onehot_index_fifo.sv
// Converts encoder one-hot left/right pairs to indices + span and buffers them behind a valid/ready FIFO.
// Optional input checking (err_o) is built when ONEHOT_CHECK_EN is defined.
module onehot_index_fifo
    import prio_enc_pkg::*;
#(
    parameter  int unsigned WIDTH = 5,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = $clog2(WIDTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic [IDX_W-1:0] span_o,
    output logic             zero_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o,
    output logic             err_o
);

    typedef struct packed {
        logic             zero;
        logic [IDX_W-1:0] span;
        logic [IDX_W-1:0] right_idx;
        logic [IDX_W-1:0] left_idx;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t     wr_entry;
    entry_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic [IDX_W-1:0] left_idx;
    logic [IDX_W-1:0] right_idx;

    assign left_idx  = IDX_W'(onehot2idx(ONEHOT_MAX_W'(data_left_i)));
    assign right_idx = IDX_W'(onehot2idx(ONEHOT_MAX_W'(data_right_i)));

    always_comb begin
        wr_entry           = '0;
        wr_entry.left_idx  = left_idx;
        wr_entry.right_idx = right_idx;
        wr_entry.span      = left_idx - right_idx;
        wr_entry.zero      = ~|data_left_i & ~|data_right_i;
    end

    assign pop = data_val_o & data_ready_i;

    sync_fifo_fwft #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (data_val_i),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign data_val_o = ~fifo_empty;

    // Head fields are forced to zero whenever nothing valid is held (including during reset).
    assign left_idx_o  = data_val_o ? head.left_idx  : '0;
    assign right_idx_o = data_val_o ? head.right_idx : '0;
    assign span_o      = data_val_o ? head.span      : '0;
    assign zero_o      = data_val_o ? head.zero      : 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (data_val_i & fifo_full & ~pop) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic bad_c;

    assign bad_c = ~is_onehot0(ONEHOT_MAX_W'(data_left_i))
                 | ~is_onehot0(ONEHOT_MAX_W'(data_right_i))
                 | ((~|data_left_i) ^ (~|data_right_i))
                 | (right_idx > left_idx);

    // Malformed pairs are still stored; only the sticky flag records them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_o <= 1'b0;
        end else if (data_val_i & bad_c) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_index_fifo.sv
// Self-checking bench for onehot_index_fifo against a queue-based reference model.
module tb_onehot_index_fifo;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             data_val_i;
    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_ready_i;
    logic             data_val_o;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic [IDX_W-1:0] span_o;
    logic             zero_o;
    logic [LVL_W-1:0] level_o;
    logic             overflow_o;
    logic             err_o;

    typedef struct {
        int l;
        int r;
        int s;
        bit z;
    } exp_t;

    exp_t q[$];
    bit   m_ovf;
    bit   m_err;
    int   n_pass;
    int   n_total;
    bit   check_en;

    onehot_index_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_val_i   (data_val_i),
        .data_left_i  (data_left_i),
        .data_right_i (data_right_i),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
        .span_o       (span_o),
        .zero_o       (zero_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int idx_of(input logic [WIDTH-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) r = r | i;
        return r;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] rv);
        exp_t e;
        e.l = idx_of(lv);
        e.r = idx_of(rv);
        e.s = (e.l - e.r) & ((1 << IDX_W) - 1);
        e.z = (lv == 0) && (rv == 0);
        return e;
    endfunction

    function automatic bit malformed(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] rv);
        return ($countones(lv) > 1) || ($countones(rv) > 1) ||
               ((lv == 0) != (rv == 0)) || (idx_of(rv) > idx_of(lv));
    endfunction

    function automatic logic [WIDTH-1:0] bit_at(input int i);
        logic [WIDTH-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive(input bit v, input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] rv, input bit rdy);
        data_val_i   = v;
        data_left_i  = lv;
        data_right_i = rv;
        data_ready_i = rdy;
    endtask

    // Advance one clock edge and update the reference model with what happened at it.
    task automatic tick();
        bit pop;
        bit push;
        int sz;
        sz   = q.size();
        pop  = (sz > 0) && data_ready_i;
        push = data_val_i;
        @(posedge clk_i);
        if (pop) q.delete(0);
        if (push) begin
            if (sz < int'(DEPTH) || pop) q.push_back(mk(data_left_i, data_right_i));
            else m_ovf = 1'b1;
            if (check_en && malformed(data_left_i, data_right_i)) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic apply_reset();
        drive(0, '0, '0, 0);
        rst_n_i = 1'b0;
        q.delete();
        m_ovf = 0;
        m_err = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (data_val_o !== 1'b0 || level_o !== '0 || overflow_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL reset_state: val=%b level=%0d ovf=%b err=%b, want 0 0 0 0",
                     data_val_o, level_o, overflow_o, err_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        drive(1, 5'b10000, 5'b00001, 1);
        tick();
        n_total++;
        if (data_val_o !== 1'b1 || left_idx_o !== 3'd4 || right_idx_o !== 3'd0 ||
            span_o !== 3'd4 || zero_o !== 1'b0)
            $display("FAIL basic_head: val=%b l=%0d r=%0d s=%0d z=%b, want 1 4 0 4 0",
                     data_val_o, left_idx_o, right_idx_o, span_o, zero_o);
        else n_pass++;
        drive(0, '0, '0, 1);
        tick();
        n_total++;
        if (data_val_o !== 1'b0 || level_o !== '0)
            $display("FAIL basic_drain: val=%b level=%0d, want 0 0", data_val_o, level_o);
        else n_pass++;
        drive(1, 5'b00000, 5'b00000, 1);
        tick();
        n_total++;
        if (data_val_o !== 1'b1 || zero_o !== 1'b1 || left_idx_o !== '0 ||
            right_idx_o !== '0 || span_o !== '0)
            $display("FAIL zero_word: val=%b z=%b l=%0d r=%0d s=%0d, want 1 1 0 0 0",
                     data_val_o, zero_o, left_idx_o, right_idx_o, span_o);
        else n_pass++;
        drive(0, '0, '0, 1);
        tick();
    endtask

    task automatic test_overflow();
        int el[5] = '{4, 3, 2, 4, 1};
        int er[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, bit_at(el[i]), bit_at(er[i]), 0);
            tick();
            n_total++;
            if (overflow_o !== (i == 4) || level_o !== LVL_W'((i < 4) ? i + 1 : 4))
                $display("FAIL fill_%0d: level=%0d ovf=%b, want %0d %b",
                         i, level_o, overflow_o, (i < 4) ? i + 1 : 4, i == 4);
            else n_pass++;
        end
        drive(0, '0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (data_val_o !== 1'b1 || left_idx_o !== IDX_W'(el[i]) || right_idx_o !== IDX_W'(er[i]) ||
                span_o !== IDX_W'(el[i] - er[i]))
                $display("FAIL drain_%0d: val=%b l=%0d r=%0d s=%0d, want 1 %0d %0d %0d",
                         i, data_val_o, left_idx_o, right_idx_o, span_o, el[i], er[i], el[i] - er[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (data_val_o !== 1'b0 || overflow_o !== 1'b1)
            $display("FAIL drain_end: val=%b ovf=%b, want 0 1", data_val_o, overflow_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int l;
        int r;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(WIDTH - 1, 0);
            l = $urandom_range(WIDTH - 1, r);
            drive(1, bit_at(l), bit_at(r), i >= 4);
            tick();
            if (i >= 3) begin
                n_total++;
                if (level_o !== LVL_W'(DEPTH) || overflow_o !== 1'b0 || data_val_o !== 1'b1 ||
                    left_idx_o !== IDX_W'(q[0].l) || right_idx_o !== IDX_W'(q[0].r) ||
                    span_o !== IDX_W'(q[0].s))
                    $display("FAIL b2b_%0d: level=%0d ovf=%b l=%0d r=%0d s=%0d, want %0d 0 %0d %0d %0d",
                             i, level_o, overflow_o, left_idx_o, right_idx_o, span_o,
                             DEPTH, q[0].l, q[0].r, q[0].s);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int l;
        int r;
        bit zw;
        for (int i = 0; i < 300; i++) begin
            zw = ($urandom_range(7, 0) == 0);
            r  = $urandom_range(WIDTH - 1, 0);
            l  = $urandom_range(WIDTH - 1, r);
            drive($urandom_range(1, 0) == 1, zw ? '0 : bit_at(l), zw ? '0 : bit_at(r),
                  ($urandom_range(3, 0) != 0) ^ ((i / 40) % 2 == 1));
            tick();
            n_total++;
            if (data_val_o !== (q.size() > 0) || level_o !== LVL_W'(q.size()) ||
                overflow_o !== m_ovf || err_o !== m_err)
                $display("FAIL rand_flags_%0d: val=%b level=%0d ovf=%b err=%b, want %b %0d %b %b",
                         i, data_val_o, level_o, overflow_o, err_o, q.size() > 0, q.size(), m_ovf, m_err);
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if (left_idx_o !== IDX_W'(q[0].l) || right_idx_o !== IDX_W'(q[0].r) ||
                    span_o !== IDX_W'(q[0].s) || zero_o !== q[0].z)
                    $display("FAIL rand_head_%0d: l=%0d r=%0d s=%0d z=%b, want %0d %0d %0d %b",
                             i, left_idx_o, right_idx_o, span_o, zero_o, q[0].l, q[0].r, q[0].s, q[0].z);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'b01000, bit_at(i), 0);
            tick();
        end
        drive(0, '0, '0, 0);
        #2;
        rst_n_i = 1'b0;
        q.delete();
        m_ovf = 0;
        m_err = 0;
        #1;
        n_total++;
        if (data_val_o !== 1'b0 || level_o !== '0 || overflow_o !== 1'b0 ||
            left_idx_o !== '0 || right_idx_o !== '0 || span_o !== '0 || zero_o !== 1'b0)
            $display("FAIL async_reset: val=%b level=%0d ovf=%b l=%0d r=%0d s=%0d z=%b, want all 0",
                     data_val_o, level_o, overflow_o, left_idx_o, right_idx_o, span_o, zero_o);
        else n_pass++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(1, 5'b00100, 5'b00010, 0);
        tick();
        drive(0, '0, '0, 0);
        n_total++;
        if (data_val_o !== 1'b1 || level_o !== LVL_W'(1) || left_idx_o !== 3'd2 ||
            right_idx_o !== 3'd1 || span_o !== 3'd1)
            $display("FAIL post_reset_head: val=%b level=%0d l=%0d r=%0d s=%0d, want 1 1 2 1 1",
                     data_val_o, level_o, left_idx_o, right_idx_o, span_o);
        else n_pass++;
        drive(0, '0, '0, 1);
        tick();
    endtask

    task automatic test_err();
        drive(1, 5'b00110, 5'b00010, 1);
        tick();
        n_total++;
        if (err_o !== check_en || data_val_o !== 1'b1 || left_idx_o !== 3'd3 || right_idx_o !== 3'd1)
            $display("FAIL err_set: err=%b val=%b l=%0d r=%0d, want %b 1 3 1",
                     err_o, data_val_o, left_idx_o, right_idx_o, check_en);
        else n_pass++;
        drive(1, 5'b10000, 5'b00100, 1);
        tick();
        drive(0, '0, '0, 1);
        tick();
        tick();
        n_total++;
        if (err_o !== check_en || data_val_o !== 1'b0)
            $display("FAIL err_sticky: err=%b val=%b, want %b 0", err_o, data_val_o, check_en);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
`ifdef ONEHOT_CHECK_EN
        check_en = 1'b1;
`else
        check_en = 1'b0;
`endif
        rst_n_i = 1'b0;
        drive(0, '0, '0, 0);
        test_reset();
        test_basic();
        test_overflow();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_random();
        test_async_reset();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
